// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiply datapath: default sizes, sequencer states, packing helpers.
// No logic of its own; latency not applicable.
// No flow control; consumers apply their own.
package matmul_pkg;

    localparam int MM_N       = 4;
    localparam int MM_ELEM_W  = 32;
    localparam int MM_TIMEOUT = 1024;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_RELEASE = 3'd3,
        ST_FINISH  = 3'd4
    } mm_state_e;

    // LSB of element (r,c) in a row-major packed N x N matrix
    function automatic int elem_lsb(input int r, input int c,
                                    input int n = MM_N, input int w = MM_ELEM_W);
        return (r * n + c) * w;
    endfunction

    // LSB of element k in a packed N-element vector
    function automatic int vec_lsb(input int k, input int w = MM_ELEM_W);
        return k * w;
    endfunction

endpackage

// File: rtl/matmul_scheduler.sv
// Sequences N*N row-by-column jobs through one shared inner_product unit and gathers C = A x B.
// Per job: 1 issue cycle + wait-for-done-rise + wait-for-done-fall; done pulses one cycle after the last job.
// Stalls on ip_done handshake edges; a watchdog aborts the run with err if either edge never arrives.
module matmul_scheduler
    import matmul_pkg::*;
#(
    parameter int N       = MM_N,
    parameter int ELEM_W  = MM_ELEM_W,
    parameter int TIMEOUT = MM_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [N*N*ELEM_W-1:0]   a_in,
    input  logic [N*N*ELEM_W-1:0]   b_in,
    output logic [N*ELEM_W-1:0]     ip_in1,
    output logic [N*ELEM_W-1:0]     ip_in2,
    output logic                    ip_start,
    input  logic [ELEM_W-1:0]       ip_out,
    input  logic                    ip_done,
    output logic [N*N*ELEM_W-1:0]   c_out,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam int MW  = N * N * ELEM_W;
    localparam int VW  = N * ELEM_W;
    localparam int IW  = (N > 1) ? $clog2(N) : 1;
    localparam int MIW = (MW > 1) ? $clog2(MW) : 1;
    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0]  LAST_IDX = IW'(N - 1);
    localparam logic [WDW-1:0] WD_LIMIT = WDW'(TIMEOUT - 1);

    mm_state_e         r_state;
    mm_state_e         w_state_nxt;
    logic [MW-1:0]     r_a;
    logic [MW-1:0]     r_b;
    logic [IW-1:0]     r_i;
    logic [IW-1:0]     r_j;
    logic [WDW-1:0]    r_wdog;
    logic [VW-1:0]     r_ip_in1;
    logic [VW-1:0]     r_ip_in2;
    logic              r_ip_start;
    logic [MW-1:0]     r_c;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic [VW-1:0]     w_row;
    logic [VW-1:0]     w_col;
    logic              w_tmo;
    logic              w_last;
    logic [MIW-1:0]    w_c_lsb;

    // Row i of latched A and column j of latched B, gathered element by element
    for (genvar k = 0; k < N; k++) begin : g_sel
        assign w_row[vec_lsb(k, ELEM_W) +: ELEM_W] =
            r_a[MIW'(elem_lsb(int'(r_i), k, N, ELEM_W)) +: ELEM_W];
        assign w_col[vec_lsb(k, ELEM_W) +: ELEM_W] =
            r_b[MIW'(elem_lsb(k, int'(r_j), N, ELEM_W)) +: ELEM_W];
    end

    // The watchdog value is the count of earlier WAIT/RELEASE cycles, so this is the TIMEOUT-th one
    assign w_tmo   = (r_wdog == WD_LIMIT);
    assign w_last  = (r_i == LAST_IDX) && (r_j == LAST_IDX);
    assign w_c_lsb = MIW'(elem_lsb(int'(r_i), int'(r_j), N, ELEM_W));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; a real handshake edge wins over a coincident watchdog expiry
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (start) w_state_nxt = ST_ISSUE;
            ST_ISSUE:   w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (ip_done)    w_state_nxt = ST_RELEASE;
                else if (w_tmo) w_state_nxt = ST_FINISH;
            end
            ST_RELEASE: begin
                if (!ip_done)   w_state_nxt = w_last ? ST_FINISH : ST_ISSUE;
                else if (w_tmo) w_state_nxt = ST_FINISH;
            end
            ST_FINISH:  w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // Operand latch, job indices, watchdog, result gather and registered status outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a        <= '0;
            r_b        <= '0;
            r_i        <= '0;
            r_j        <= '0;
            r_wdog     <= '0;
            r_ip_in1   <= '0;
            r_ip_in2   <= '0;
            r_ip_start <= 1'b0;
            r_c        <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a    <= a_in;
                        r_b    <= b_in;
                        r_i    <= '0;
                        r_j    <= '0;
                        r_c    <= '0;
                        r_err  <= 1'b0;
                        r_busy <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    r_ip_in1   <= w_row;
                    r_ip_in2   <= w_col;
                    r_ip_start <= 1'b1;
                    r_wdog     <= '0;
                end
                ST_WAIT: begin
                    r_wdog <= r_wdog + 1'b1;
                    if (ip_done) begin
                        r_c[w_c_lsb +: ELEM_W] <= ip_out;
                        r_ip_start             <= 1'b0;
                    end else if (w_tmo) begin
                        r_ip_start <= 1'b0;
                        r_err      <= 1'b1;
                    end
                end
                ST_RELEASE: begin
                    r_wdog <= r_wdog + 1'b1;
                    if (!ip_done) begin
                        if (r_j == LAST_IDX) begin
                            r_j <= '0;
                            r_i <= r_i + 1'b1;
                        end else begin
                            r_j <= r_j + 1'b1;
                        end
                    end else if (w_tmo) begin
                        r_err <= 1'b1;
                    end
                end
                default: ;
            endcase
            // Any route into FINISH (normal or aborted) ends the run
            if ((w_state_nxt == ST_FINISH) && (r_state != ST_FINISH)) begin
                r_done <= 1'b1;
                r_busy <= 1'b0;
            end
        end
    end

    assign ip_in1   = r_ip_in1;
    assign ip_in2   = r_ip_in2;
    assign ip_start = r_ip_start;
    assign c_out    = r_c;
    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;

endmodule

// File: doc/matmul_scheduler.md
# matmul_scheduler

Sequencer that computes C = A × B for N×N IEEE-754 single-precision matrices by time-sharing one `inner_product` unit. It latches both operand matrices on `start`, then issues N² row·column jobs in row-major order. For each job it collects the scalar result into the C buffer and signals `done` when the product is complete. It sits between the matrix-multiplier top level and the single `inner_product` instance, which is wired beside it rather than instantiated inside it.

## Interface
- `N`, 4: matrix dimension; must equal the `inner_product` element count.
- `ELEM_W`, 32: element width (IEEE-754 single).
- `TIMEOUT`, 1024: maximum cycles spent waiting on either `ip_done` edge before the run aborts.
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: reset, asynchronous, active-low (low = reset).
- `start` in 1: level request; sampled only in IDLE.
- `a_in` in N·N·ELEM_W: matrix A; element (r,c) occupies bits [(r·N+c)·ELEM_W +: ELEM_W].
- `b_in` in N·N·ELEM_W: matrix B, same packing.
- `ip_in1` out N·ELEM_W: row i of A; element k occupies [k·ELEM_W +: ELEM_W].
- `ip_in2` out N·ELEM_W: column j of B, same packing.
- `ip_start` out 1: start to `inner_product`.
- `ip_out` in ELEM_W: `inner_product` result.
- `ip_done` in 1: `inner_product` done.
- `c_out` out N·N·ELEM_W: result matrix, same packing as `a_in`.
- `busy` out 1: high from the start-accept cycle until the cycle after the last job.
- `done` out 1: one-cycle pulse at the end of a run.
- `err` out 1: sticky timeout flag; cleared on the next accepted start.

## Operation
- States:
  - IDLE: wait for `start`.
  - ISSUE: drive operands and `ip_start`.
  - WAIT: wait for `ip_done` to rise.
  - RELEASE: wait for `ip_done` to fall.
  - FINISH: pulse `done`.
- IDLE → ISSUE when `start`=1:
  - latch `a_in`/`b_in` into internal registers;
  - set i=j=0, clear `c_out` and `err`, set `busy`=1.
- ISSUE → WAIT, unconditionally after 1 cycle.
  - `ip_in1`/`ip_in2` are registered from the latched A row i and B column j.
  - `ip_start` goes to 1 and stays 1 through WAIT.
- WAIT → RELEASE when `ip_done`=1:
  - write `ip_out` into C(i,j);
  - drop `ip_start` to 0.
- RELEASE → next job when `ip_done`=0:
  - advance j; on j wrapping from N−1 to 0, advance i;
  - go to ISSUE, or to FINISH when (i,j) was (N−1,N−1).
  - No new `ip_start` is ever raised while `ip_done` is still 1, so there is no double issue.
- FINISH → IDLE after 1 cycle, with `done`=1 and `busy`=0.
  - `c_out` holds its value until the next accepted start.
- Timeout:
  - A watchdog counts consecutive cycles spent in WAIT plus RELEASE; it resets at each ISSUE.
  - On reaching TIMEOUT: `err`=1, `ip_start`=0, go to FINISH.
  - `c_out` keeps the results completed so far; entries not yet computed stay 0.
- `start` while not in IDLE is ignored. Changes to `a_in`/`b_in` after the accept cycle have no effect.
- Counter widths: i and j are clog2(N) bits (minimum 1); the watchdog is clog2(TIMEOUT+1) bits.

## Timing
- Reset (`rst` low), asynchronous: state=IDLE; every output (`ip_in1`, `ip_in2`, `ip_start`, `c_out`, `busy`, `done`, `err`) and all internal registers are 0.
- Reset mid-run aborts immediately, with no `done` pulse. After `rst` returns high, the next `start` runs normally.
- Start accept is cycle 0. ISSUE of job 0 is in cycle 1.
- Per-job cycle count = 1 (ISSUE) + W + R, where:
  - W = cycles in WAIT, ≥1;
  - R = cycles in RELEASE, ≥1.
- `done` is asserted in the cycle after the last RELEASE exit.
- All outputs are registered, with no combinational path from input to output.

## Structure
- Shared package `matmul_pkg` holds:
  - default ELEM_W, N, TIMEOUT;
  - the state enum;
  - index helpers elem_lsb(r,c) and vec_lsb(k).
- The `inner_product` module imports the same package.
- No sub-module needed. Row/column extraction is a generate loop in this block.
- The top-level `matrix_multiplier` instantiates `matmul_scheduler` and `inner_product` side by side.

## Test plan
All scenarios use a behavioural `inner_product` model with latency L=3: `ip_done` rises 3 cycles after `ip_start` is sampled high, and falls 1 cycle after `ip_start` falls. Test values: 1.0=32'h3F800000, 2.0=32'h40000000.

- Reset: `rst`=0 with random inputs → all outputs 0. Release with `start`=0 → stays in IDLE, `busy`=0.
- Identity: A=I (1.0 on the diagonal), B(r,c)=distinct floats → `c_out`==B. Also check:
  - jobs issued in order (0,0),(0,1)…(3,3);
  - exactly 16 `ip_start` rising edges;
  - a single `done` pulse, `err`=0.
- Busy lockout: pulse `start` again at job 5 with A=all-2.0 → ignored; result still equals B and only 16 jobs are issued.
- Slow release: the model holds `ip_done` high for 6 cycles after `ip_start` falls → no new `ip_start` until `ip_done`=0; results still correct.
- Timeout: TIMEOUT=16 and the model never raises `ip_done` on job 2 → `err`=1, `done` pulse, `ip_start`=0. C(0,0) and C(0,1) are valid and all other entries are 0. The next start clears `err`.
- Reset mid-run: `rst` low during job 7 → all outputs 0 in the same cycle and no `done`. Restart with A=I completes with `c_out`==B.
